// File: rtl/ast_pkg.sv
// Shared types and width helpers for the one-hot Avalon-ST demux.
package ast_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } ast_state_e;

  // Empty field width: a single-symbol beat still carries a 1-bit empty.
  function automatic int empty_w(input int symbols);
    return (symbols <= 1) ? 1 : $clog2(symbols);
  endfunction

  // Direction pointer width: at least one bit, even for a single direction.
  function automatic int ptr_w(input int dirs);
    return (dirs <= 1) ? 1 : $clog2(dirs);
  endfunction

endpackage

// File: rtl/one_hot_ast_demux_if.sv
// Avalon-ST bundle: one sink stream in, OUT_DIRS_CNT source streams out.
interface one_hot_ast_demux_if
  import ast_pkg::*;
#(
  parameter int BYTE_W       = 8,
  parameter int OUT_DIRS_CNT = 8,
  parameter int AST_SYMBOLS  = 1,
  parameter int AST_EMPTY_W  = empty_w(AST_SYMBOLS)
);
  localparam int DATA_W = AST_SYMBOLS * BYTE_W;

  logic [DATA_W-1:0]                          ast_sink_data_i;
  logic                                       ast_sink_valid_i;
  logic                                       ast_sink_ready_o;
  logic [AST_EMPTY_W-1:0]                     ast_sink_empty_i;
  logic                                       ast_sink_startofpacket_i;
  logic                                       ast_sink_endofpacket_i;

  logic [OUT_DIRS_CNT-1:0][DATA_W-1:0]        ast_source_data_o;
  logic [OUT_DIRS_CNT-1:0]                    ast_source_valid_o;
  logic [OUT_DIRS_CNT-1:0]                    ast_source_ready_i;
  logic [OUT_DIRS_CNT-1:0][AST_EMPTY_W-1:0]   ast_source_empty_o;
  logic [OUT_DIRS_CNT-1:0]                    ast_source_startofpacket_o;
  logic [OUT_DIRS_CNT-1:0]                    ast_source_endofpacket_o;

  // Environment side: produces the sink stream, consumes the sources.
  modport master (
    output ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
           ast_sink_startofpacket_i, ast_sink_endofpacket_i,
    input  ast_sink_ready_o,
    input  ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
           ast_source_startofpacket_o, ast_source_endofpacket_o,
    output ast_source_ready_i
  );

  // Demux side.
  modport slave (
    input  ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
           ast_sink_startofpacket_i, ast_sink_endofpacket_i,
    output ast_sink_ready_o,
    output ast_source_data_o, ast_source_valid_o, ast_source_empty_o,
           ast_source_startofpacket_o, ast_source_endofpacket_o,
    input  ast_source_ready_i
  );
endinterface

// File: rtl/ast_pipe_stage.sv
// One-entry valid/ready register; accepts a new word in the same cycle the
// held word leaves, so a ready consumer sees full throughput.
module ast_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_vld_p1;
  logic [W-1:0] r_data_p1;

  assign o_ready = !r_vld_p1 || i_ready;
  assign o_valid = r_vld_p1;
  assign o_data  = r_data_p1;

  // Occupancy flag: refilled or emptied whenever the held word can move.
  always_ff @(posedge clk_i) begin
    if (srst_i)       r_vld_p1 <= 1'b0;
    else if (o_ready) r_vld_p1 <= i_valid;
  end

  // Payload: captured only on an actual load, otherwise held stable.
  always_ff @(posedge clk_i) begin
    if (i_valid && o_ready) r_data_p1 <= i_data;
  end
endmodule

// File: rtl/one_hot_ast_demux.sv
// Round-robin packet demux: each whole packet goes to one direction, beats
// outside a packet are discarded and counted.
module one_hot_ast_demux
  import ast_pkg::*;
#(
  parameter int BYTE_W       = 8,
  parameter int OUT_DIRS_CNT = 8,
  parameter int AST_SYMBOLS  = 1,
  parameter int AST_EMPTY_W  = empty_w(AST_SYMBOLS)
) (
  input  logic                clk_i,
  input  logic                srst_i,
  one_hot_ast_demux_if.slave  bus,
  output logic [15:0]         drop_cnt_o
);
  localparam int DATA_W = AST_SYMBOLS * BYTE_W;
  localparam int PTR_W  = ptr_w(OUT_DIRS_CNT);
  localparam int STG_W  = DATA_W + AST_EMPTY_W + 2 + PTR_W;

  ast_state_e         r_state;
  logic [PTR_W-1:0]   r_dir_ptr;
  logic [PTR_W-1:0]   r_dest;
  logic [15:0]        r_drop_cnt;

  logic               w_drop;
  logic               w_accept;
  logic               w_stage_rdy;
  logic               w_stage_vld_p0;
  logic [PTR_W-1:0]   w_dest_p0;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [STG_W-1:0]   w_stg_d_p0;

  logic               w_vld_p1;
  logic               w_dest_rdy_p1;
  logic [STG_W-1:0]   w_stg_q_p1;
  logic [DATA_W-1:0]  w_data_p1;
  logic [AST_EMPTY_W-1:0] w_empty_p1;
  logic               w_sop_p1;
  logic               w_eop_p1;
  logic [PTR_W-1:0]   w_dest_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A beat with no packet open is swallowed regardless of output state.
  assign w_drop    = (r_state == ST_IDLE) && !bus.ast_sink_startofpacket_i;
  assign w_dest_p0 = (r_state == ST_IDLE) ? r_dir_ptr : r_dest;
  assign w_ptr_nxt = (r_dir_ptr == PTR_W'(OUT_DIRS_CNT - 1)) ? '0 : r_dir_ptr + PTR_W'(1);

  assign bus.ast_sink_ready_o = srst_i ? 1'b0 : (w_drop ? 1'b1 : w_stage_rdy);
  assign w_accept       = bus.ast_sink_valid_i && bus.ast_sink_ready_o;
  assign w_stage_vld_p0 = bus.ast_sink_valid_i && !w_drop;
  assign w_stg_d_p0     = {bus.ast_sink_data_i, bus.ast_sink_empty_i,
                           bus.ast_sink_startofpacket_i, bus.ast_sink_endofpacket_i,
                           w_dest_p0};

  // Packet framing FSM: tracks open packet, dest, rotation and drop count.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= ST_IDLE;
      r_dir_ptr  <= '0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.ast_sink_startofpacket_i) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
          end else if (bus.ast_sink_endofpacket_i) begin
            r_dir_ptr <= w_ptr_nxt;
          end else begin
            r_dest  <= r_dir_ptr;
            r_state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (bus.ast_sink_endofpacket_i) begin
            r_dir_ptr <= w_ptr_nxt;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign drop_cnt_o = r_drop_cnt;

  // ---- p0 -> p1: output register stage ----
  ast_pipe_stage #(.W(STG_W)) u_stage (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_valid (w_stage_vld_p0),
    .o_ready (w_stage_rdy),
    .i_data  (w_stg_d_p0),
    .o_valid (w_vld_p1),
    .i_ready (w_dest_rdy_p1),
    .o_data  (w_stg_q_p1)
  );

  assign {w_data_p1, w_empty_p1, w_sop_p1, w_eop_p1, w_dest_p1} = w_stg_q_p1;

  // Only the held beat's own direction can release the stage.
  always_comb begin
    w_dest_rdy_p1 = 1'b0;
    for (int i = 0; i < OUT_DIRS_CNT; i++) begin
      if (w_dest_p1 == PTR_W'(i)) w_dest_rdy_p1 = bus.ast_source_ready_i[i];
    end
  end

  // One-hot valid on the destination; payload broadcast to every direction.
  always_comb begin
    bus.ast_source_valid_o         = '0;
    bus.ast_source_data_o          = '0;
    bus.ast_source_empty_o         = '0;
    bus.ast_source_startofpacket_o = '0;
    bus.ast_source_endofpacket_o   = '0;
    for (int i = 0; i < OUT_DIRS_CNT; i++) begin
      bus.ast_source_valid_o[i]         = w_vld_p1 && (w_dest_p1 == PTR_W'(i));
      bus.ast_source_data_o[i]          = w_data_p1;
      bus.ast_source_empty_o[i]         = w_empty_p1;
      bus.ast_source_startofpacket_o[i] = w_sop_p1;
      bus.ast_source_endofpacket_o[i]   = w_eop_p1;
    end
  end
endmodule

// File: tb/tb_one_hot_ast_demux.sv
// Bench for one_hot_ast_demux: a 4-direction instance checked by a
// packet-level scoreboard plus a 1-direction instance.
module tb_one_hot_ast_demux;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  one_hot_ast_demux_if #(.BYTE_W(8), .OUT_DIRS_CNT(4), .AST_SYMBOLS(2), .AST_EMPTY_W(1)) if4 ();
  one_hot_ast_demux_if #(.BYTE_W(8), .OUT_DIRS_CNT(1), .AST_SYMBOLS(1), .AST_EMPTY_W(1)) if1 ();
  logic [15:0] drop4, drop1;

  one_hot_ast_demux #(.BYTE_W(8), .OUT_DIRS_CNT(4), .AST_SYMBOLS(2), .AST_EMPTY_W(1)) u_dut4 (
    .clk_i(clk), .srst_i(rst), .bus(if4), .drop_cnt_o(drop4));
  one_hot_ast_demux #(.BYTE_W(8), .OUT_DIRS_CNT(1), .AST_SYMBOLS(1), .AST_EMPTY_W(1)) u_dut1 (
    .clk_i(clk), .srst_i(rst), .bus(if1), .drop_cnt_o(drop1));

  typedef struct {
    int          dir;
    logic [DW-1:0] data;
    logic        empty;
    logic        sop;
    logic        eop;
  } beat_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    dir_beats[4];
  int    snap[4];
  beat_t q[$];
  bit    m_in_pkt;
  int    m_pkt;
  int    m_drop;
  bit    rand_rdy = 0;

  // Reference: packet k (counting from reset) goes to direction k mod 4;
  // beats outside a packet are dropped; one beat at most in flight.
  task automatic sb_monitor;
    beat_t h;
    logic  exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete(); m_in_pkt = 0; m_pkt = 0; m_drop = 0;
        n_checks++;
        if (if4.ast_sink_ready_o !== 1'b0) $display("FAIL sink_ready_in_reset: got %b want 0", if4.ast_sink_ready_o);
        else n_pass++;
      end else begin
        exp_rdy = (q.size() == 0) ? 1'b1 : if4.ast_source_ready_i[q[0].dir];
        if (!m_in_pkt && !if4.ast_sink_startofpacket_i) exp_rdy = 1'b1;
        if (if4.ast_sink_valid_i === 1'b1) begin
          n_checks++;
          if (if4.ast_sink_ready_o !== exp_rdy) $display("FAIL sink_ready: got %b want %b cyc %0d", if4.ast_sink_ready_o, exp_rdy, cyc);
          else n_pass++;
        end
        if (q.size() == 0) begin
          n_checks++;
          if (if4.ast_source_valid_o !== 4'b0) $display("FAIL idle_valid: got %b want 0000 cyc %0d", if4.ast_source_valid_o, cyc);
          else n_pass++;
        end else begin
          h = q[0];
          n_checks++;
          if (if4.ast_source_valid_o !== 4'(1 << h.dir)) $display("FAIL dest_valid: got %b want dir %0d cyc %0d", if4.ast_source_valid_o, h.dir, cyc);
          else n_pass++;
          n_checks++;
          if (if4.ast_source_data_o !== {4{h.data}}) $display("FAIL beat_data: got %h want 4x%h cyc %0d", if4.ast_source_data_o, h.data, cyc);
          else n_pass++;
          n_checks++;
          if ({if4.ast_source_empty_o[h.dir], if4.ast_source_startofpacket_o[h.dir], if4.ast_source_endofpacket_o[h.dir]}
              !== {h.empty, h.sop, h.eop})
            $display("FAIL beat_ctl: got %b%b%b want %b%b%b cyc %0d", if4.ast_source_empty_o[h.dir],
                     if4.ast_source_startofpacket_o[h.dir], if4.ast_source_endofpacket_o[h.dir], h.empty, h.sop, h.eop, cyc);
          else n_pass++;
          if (if4.ast_source_ready_i[h.dir]) begin
            dir_beats[h.dir]++;
            void'(q.pop_front());
          end
        end
        if (if4.ast_sink_valid_i === 1'b1 && if4.ast_sink_ready_o === 1'b1) begin
          if (!m_in_pkt && !if4.ast_sink_startofpacket_i) begin
            if (m_drop < 65535) m_drop++;
          end else begin
            h.dir = m_pkt % 4; h.data = if4.ast_sink_data_i; h.empty = if4.ast_sink_empty_i;
            h.sop = if4.ast_sink_startofpacket_i; h.eop = if4.ast_sink_endofpacket_i;
            q.push_back(h);
            if (h.eop) begin m_pkt++; m_in_pkt = 0; end
            else m_in_pkt = 1;
          end
        end
      end
    end
  endtask

  task automatic ready_driver;
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) if4.ast_source_ready_i = 4'($urandom);
    end
  endtask

  task automatic send4(input logic [DW-1:0] d, input logic em, input logic so, input logic eo);
    bit got;
    got = 0;
    if4.ast_sink_data_i = d; if4.ast_sink_empty_i = em;
    if4.ast_sink_startofpacket_i = so; if4.ast_sink_endofpacket_i = eo;
    if4.ast_sink_valid_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (if4.ast_sink_ready_o === 1'b1) begin got = 1; break; end
    end
    @(posedge clk); #1;
    if4.ast_sink_valid_i = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL send_timeout: got no ready want ready within 100 cycles");
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; if4.ast_sink_valid_i = 1'b0; if1.ast_sink_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic take_snap;
    for (int i = 0; i < 4; i++) snap[i] = dir_beats[i];
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if4.ast_sink_ready_o, if4.ast_source_valid_o, drop4} !== 21'b0)
      $display("FAIL reset_dut4: got rdy %b vld %b drop %h want all 0", if4.ast_sink_ready_o, if4.ast_source_valid_o, drop4);
    else n_pass++;
    n_checks++;
    if ({if1.ast_sink_ready_o, if1.ast_source_valid_o, drop1} !== 18'b0)
      $display("FAIL reset_dut1: got rdy %b vld %b drop %h want all 0", if1.ast_sink_ready_o, if1.ast_source_valid_o, drop1);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_four_pkts;
    int c0;
    do_reset; if4.ast_source_ready_i = 4'hF; take_snap;
    c0 = cyc;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 3; b++) send4(16'($urandom), 1'($urandom), b == 0, b == 2);
    n_checks++;
    if (cyc - c0 !== 12) $display("FAIL no_bubble: got %0d cycles want 12", cyc - c0);
    else n_pass++;
    drain;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dir_beats[i] - snap[i] !== 3) $display("FAIL four_pkts_dir%0d: got %0d beats want 3", i, dir_beats[i] - snap[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single_beats;
    int want[4];
    want = '{2, 1, 1, 1};
    do_reset; if4.ast_source_ready_i = 4'hF; take_snap;
    for (int p = 0; p < 5; p++) send4(16'($urandom), 1'($urandom), 1'b1, 1'b1);
    drain;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dir_beats[i] - snap[i] !== want[i]) $display("FAIL single_dir%0d: got %0d want %0d", i, dir_beats[i] - snap[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    logic [DW-1:0] b1, b2;
    b1 = 16'($urandom); b2 = 16'($urandom);
    do_reset; if4.ast_source_ready_i = 4'hF;
    send4(16'($urandom), 1'b0, 1'b1, 1'b0);
    send4(16'($urandom), 1'b0, 1'b0, 1'b1);
    take_snap;
    if4.ast_source_ready_i = 4'b1101;
    send4(b1, 1'b0, 1'b1, 1'b0);
    if4.ast_sink_data_i = b2; if4.ast_sink_startofpacket_i = 1'b0; if4.ast_sink_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (if4.ast_sink_ready_o !== 1'b0) $display("FAIL stall_sink_ready: got %b want 0 k %0d", if4.ast_sink_ready_o, k);
      else n_pass++;
      n_checks++;
      if (if4.ast_source_valid_o !== 4'b0010 || if4.ast_source_data_o[1] !== b1)
        $display("FAIL stall_hold: got vld %b data %h want 0010 %h", if4.ast_source_valid_o, if4.ast_source_data_o[1], b1);
      else n_pass++;
    end
    @(posedge clk); #1 if4.ast_source_ready_i = 4'hF;
    send4(b2, 1'b0, 1'b0, 1'b0);
    send4(16'($urandom), 1'b1, 1'b0, 1'b1);
    drain;
    n_checks++;
    if (dir_beats[1] - snap[1] !== 3) $display("FAIL stall_resume: got %0d beats want 3", dir_beats[1] - snap[1]);
    else n_pass++;
  endtask

  task automatic test_drop;
    do_reset; if4.ast_source_ready_i = 4'hF;
    for (int k = 0; k < 3; k++) send4(16'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    n_checks++;
    if (drop4 !== 16'd3) $display("FAIL drop_count: got %0d want 3", drop4);
    else n_pass++;
    take_snap;
    send4(16'($urandom), 1'b0, 1'b1, 1'b1);
    drain;
    n_checks++;
    if (dir_beats[0] - snap[0] !== 1) $display("FAIL drop_ptr: got %0d beats on dir0 want 1", dir_beats[0] - snap[0]);
    else n_pass++;
    force u_dut4.r_drop_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release u_dut4.r_drop_cnt;
    send4(16'($urandom), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (drop4 !== 16'hFFFF) $display("FAIL drop_saturate: got %h want ffff", drop4);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset; if4.ast_source_ready_i = 4'hF;
    send4(16'($urandom), 1'b0, 1'b1, 1'b0);
    send4(16'($urandom), 1'b0, 1'b0, 1'b1);
    send4(16'($urandom), 1'b0, 1'b1, 1'b1);
    send4(16'($urandom), 1'b0, 1'b1, 1'b0);
    if4.ast_sink_data_i = 16'($urandom); if4.ast_sink_startofpacket_i = 1'b0;
    if4.ast_sink_valid_i = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if4.ast_sink_ready_o !== 1'b0) $display("FAIL mid_reset_ready: got %b want 0", if4.ast_sink_ready_o);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0; if4.ast_sink_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if4.ast_source_valid_o !== 4'b0) $display("FAIL mid_reset_valid: got %b want 0000", if4.ast_source_valid_o);
    else n_pass++;
    @(posedge clk); #1;
    take_snap;
    send4(16'($urandom), 1'b0, 1'b1, 1'b1);
    drain;
    n_checks++;
    if (dir_beats[0] - snap[0] !== 1 || dir_beats[2] - snap[2] !== 0)
      $display("FAIL mid_reset_dir0: got dir0 %0d dir2 %0d want 1 0", dir_beats[0] - snap[0], dir_beats[2] - snap[2]);
    else n_pass++;
  endtask

  task automatic test_random;
    int ng, len;
    logic so;
    do_reset; rand_rdy = 1;
    for (int p = 0; p < 20; p++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) send4(16'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        so = (b == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        send4(16'($urandom), 1'($urandom), so, b == len - 1);
      end
    end
    rand_rdy = 0;
    @(posedge clk); #1 if4.ast_source_ready_i = 4'hF;
    drain;
    n_checks++;
    if (drop4 !== 16'(m_drop)) $display("FAIL random_drop: got %0d want %0d", drop4, m_drop);
    else n_pass++;
    n_checks++;
    if (q.size() !== 0) $display("FAIL random_drain: got %0d pending want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_one_dir;
    logic [7:0] d, prev_d;
    bit have_prev;
    int len;
    do_reset; if1.ast_source_ready_i = 1'b1; have_prev = 0; prev_d = '0;
    for (int p = 0; p < 4; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        if1.ast_sink_data_i = d; if1.ast_sink_empty_i = 1'b0;
        if1.ast_sink_startofpacket_i = (b == 0); if1.ast_sink_endofpacket_i = (b == len - 1);
        if1.ast_sink_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if1.ast_sink_ready_o !== 1'b1) $display("FAIL one_dir_ready: got %b want 1", if1.ast_sink_ready_o);
        else n_pass++;
        if (have_prev) begin
          n_checks++;
          if (if1.ast_source_valid_o !== 1'b1 || if1.ast_source_data_o[0] !== prev_d)
            $display("FAIL one_dir_out: got vld %b data %h want 1 %h", if1.ast_source_valid_o, if1.ast_source_data_o[0], prev_d);
          else n_pass++;
        end
        prev_d = d; have_prev = 1;
        @(posedge clk); #1;
      end
    end
    if1.ast_sink_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if1.ast_source_valid_o !== 1'b1 || if1.ast_source_data_o[0] !== prev_d)
      $display("FAIL one_dir_last: got vld %b data %h want 1 %h", if1.ast_source_valid_o, if1.ast_source_data_o[0], prev_d);
    else n_pass++;
    n_checks++;
    if (u_dut1.r_dir_ptr !== 1'b0 || drop1 !== 16'd0)
      $display("FAIL one_dir_ptr: got ptr %b drop %0d want 0 0", u_dut1.r_dir_ptr, drop1);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dir_beats[i] = 0;
    if4.ast_sink_valid_i = 1'b0; if4.ast_sink_data_i = '0; if4.ast_sink_empty_i = '0;
    if4.ast_sink_startofpacket_i = 1'b0; if4.ast_sink_endofpacket_i = 1'b0;
    if4.ast_source_ready_i = 4'hF;
    if1.ast_sink_valid_i = 1'b0; if1.ast_sink_data_i = '0; if1.ast_sink_empty_i = '0;
    if1.ast_sink_startofpacket_i = 1'b0; if1.ast_sink_endofpacket_i = 1'b0;
    if1.ast_source_ready_i = 1'b1;
    fork
      sb_monitor();
      ready_driver();
    join_none
    test_reset;
    test_four_pkts;
    test_single_beats;
    test_stall;
    test_drop;
    test_reset_mid;
    test_random;
    test_one_dir;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/one_hot_ast_demux.md
ONE_HOT_AST_DEMUX -- requirements
Module: one_hot_ast_demux

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter OUT_DIRS_CNT, default 8, number of output directions (>=1).
REQ-003 SHALL have parameter AST_SYMBOLS, default 1, symbols per beat.
REQ-004 SHALL have parameter AST_EMPTY_W, default 1 if AST_SYMBOLS==1 else clog2(AST_SYMBOLS), empty field width.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port srst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports ast_sink_data_i  input  AST_SYMBOLS*BYTE_W; ast_sink_valid_i  input  1; ast_sink_ready_o  output  1; ast_sink_empty_i  input  AST_EMPTY_W; ast_sink_startofpacket_i / ast_sink_endofpacket_i  input  1 each -- single Avalon-ST input.
REQ-008 SHALL have ports ast_source_data_o  output  OUT_DIRS_CNT x AST_SYMBOLS*BYTE_W; ast_source_valid_o  output  OUT_DIRS_CNT; ast_source_ready_i  input  OUT_DIRS_CNT; ast_source_empty_o  output  OUT_DIRS_CNT x AST_EMPTY_W; ast_source_startofpacket_o / ast_source_endofpacket_o  output  OUT_DIRS_CNT each -- per-direction Avalon-ST outputs.
REQ-009 SHALL have port drop_cnt_o  output  16  saturating count of discarded beats.

Function
REQ-010 SHALL distribute whole packets from sink to one direction each, strict round-robin order 0,1,...,OUT_DIRS_CNT-1,0.
REQ-011 SHALL keep FSM states IDLE (between packets) and PKT (packet in progress), plus pointer dir_ptr (width max(1,clog2(OUT_DIRS_CNT))).
REQ-012 SHALL, in IDLE, on accepted beat with sop=1, eop=0: latch dest=dir_ptr, go to PKT.
REQ-013 SHALL, in IDLE, on accepted beat with sop=1, eop=1: send to dir_ptr, advance dir_ptr, stay IDLE.
REQ-014 SHALL, in IDLE, accept and discard any beat with sop=0 (sink ready=1 regardless of outputs) and increment drop_cnt_o, saturating at 0xFFFF.
REQ-015 SHALL, in PKT, forward every beat to latched dest unchanged, including a stray sop=1 beat.
REQ-016 SHALL, in PKT, on accepted beat with eop=1: advance dir_ptr (wrap OUT_DIRS_CNT-1 -> 0), go IDLE; next beat may be accepted the following cycle (no bubble).
REQ-017 SHALL register outputs in a one-entry stage holding {data, empty, sop, eop, dest}; latency sink accept -> source valid exactly 1 cycle.
REQ-018 SHALL drive ast_source_valid_o[dest]=stage valid and all other valid bits 0; data/empty/sop/eop broadcast to all directions from the stage.
REQ-019 SHALL drive ast_sink_ready_o (forwarding case) = !stage_valid || ast_source_ready_i[stage_dest], giving full throughput when the destination is ready.
REQ-020 SHALL hold stage contents stable while stage valid and destination ready low.
REQ-021 SHALL never present a beat to a direction other than its packet's dest; ready of non-dest directions has no effect.

Reset
REQ-022 SHALL, while srst_i high, clear: state=IDLE, dir_ptr=0, stage valid=0 (all ast_source_valid_o=0), drop_cnt_o=0; ast_sink_ready_o=0.
REQ-023 SHALL abandon any partial packet on reset mid-packet; first post-reset packet goes to direction 0.

Structure
REQ-024 SHALL take AST_EMPTY_W derivation and FSM state enum from shared package ast_pkg.
REQ-025 SHALL implement the output register as sub-module ast_pipe_stage (valid/ready one-entry register).

Verification
REQ-026 SHALL cover: OUT_DIRS_CNT=4, four 3-beat packets, all ready=1 -> packets on dirs 0,1,2,3, each beat 1 cycle after accept, no bubbles.
REQ-027 SHALL cover: single-beat packets (sop=eop=1) x5 -> dirs 0,1,2,3,0.
REQ-028 SHALL cover: ready[1]=0 during packet to dir 1 for 10 cycles -> sink ready=0, stage data stable, no valid on other dirs; resumes on ready.
REQ-029 SHALL cover: 3 beats sop=0 in IDLE -> discarded, drop_cnt_o=3, dir_ptr unchanged; force count to 0xFFFF then drop -> stays 0xFFFF.
REQ-030 SHALL cover: srst_i asserted on beat 2 of packet to dir 2 -> all valid 0 next cycle, next packet to dir 0.
REQ-031 SHALL cover: OUT_DIRS_CNT=1 -> all packets to dir 0, pointer stays 0.
